// File: rtl/gpa_spi_multi_iface.sv
// rtl/gpa_spi_multi_iface.sv - multi-chip-select SPI master with command FIFO and MISO readback
module gpa_spi_multi_iface #(
    parameter int FRAME_W    = 24,
    parameter int CS_BITS    = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [31:0]            data_i,
    input  logic                   valid_i,
    input  logic [DIV_W-1:0]       spi_clk_div_i,
    input  logic                   err_clr_i,
    output logic                   full_o,
    output logic                   busy_o,
    output logic                   overflow_o,
    output logic                   fhd_clk_o,
    output logic                   fhd_sdo_o,
    input  logic                   fhd_sdi_i,
    output logic [2**CS_BITS-1:0]  fhd_csn_o,
    output logic [FRAME_W-1:0]     rdata_o,
    output logic [CS_BITS-1:0]     rcs_o,
    output logic                   rvalid_o
);
    localparam int N_CS = 2**CS_BITS;
    localparam int EW   = FRAME_W + CS_BITS + 1;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int HW   = $clog2(2*FRAME_W);

    localparam logic [AW:0]     CNT_ONE   = 1;
    localparam logic [AW:0]     CNT_FULL  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW-1:0]   PTR_ONE   = 1;
    localparam logic [DIV_W:0]  DIV_ONE   = 1;
    localparam logic [HW-1:0]   HALF_ONE  = 1;
    localparam logic [HW-1:0]   HALF_LAST = HW'(2*FRAME_W-1);
    localparam logic [N_CS-1:0] CS_ONE    = 1;

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;

    logic [EW-1:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [AW:0]        count;
    logic               push, drop, pop;
    logic [EW-1:0]      wr_word, rd_word;
    logic [CS_BITS-1:0] rd_cs;

    state_t             state;
    logic [DIV_W:0]     h, cnt;
    logic [HW-1:0]      half_cnt;
    logic [FRAME_W-1:0] tx, rx;
    logic               rb;
    logic [CS_BITS-1:0] cs_idx;
    logic               half_done;
    logic               unused_data;

    // Only payload, chip-select index and readback flag are stored per entry.
    assign wr_word     = {data_i[31], data_i[FRAME_W +: CS_BITS], data_i[FRAME_W-1:0]};
    assign unused_data = ^data_i;
    assign rd_word     = mem[rd_ptr];
    assign rd_cs       = rd_word[FRAME_W +: CS_BITS];

    assign full_o    = (count == CNT_FULL);
    assign push      = valid_i && !full_o;
    assign drop      = valid_i && full_o;
    assign pop       = (state == IDLE) && (count != '0);
    assign half_done = (cnt == h - DIV_ONE);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_word;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (drop)
                overflow_o <= 1'b1;
            else if (err_clr_i)
                overflow_o <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            h         <= '0;
            cnt       <= '0;
            half_cnt  <= '0;
            tx        <= '0;
            rx        <= '0;
            rb        <= 1'b0;
            cs_idx    <= '0;
            busy_o    <= 1'b0;
            fhd_clk_o <= 1'b0;
            fhd_sdo_o <= 1'b0;
            fhd_csn_o <= '1;
            rdata_o   <= '0;
            rcs_o     <= '0;
            rvalid_o  <= 1'b0;
        end else begin
            rvalid_o <= 1'b0;
            case (state)
                IDLE: begin
                    busy_o <= pop;
                    if (pop) begin
                        h         <= {1'b0, spi_clk_div_i} + DIV_ONE;
                        cnt       <= '0;
                        half_cnt  <= '0;
                        tx        <= rd_word[FRAME_W-1:0];
                        fhd_sdo_o <= rd_word[FRAME_W-1];
                        rb        <= rd_word[EW-1];
                        cs_idx    <= rd_cs;
                        fhd_csn_o <= ~(CS_ONE << rd_cs);
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (half_done) begin
                        cnt       <= '0;
                        half_cnt  <= half_cnt + HALF_ONE;
                        fhd_clk_o <= ~fhd_clk_o;
                        if (!fhd_clk_o) begin
                            rx <= {rx[FRAME_W-2:0], fhd_sdi_i};
                        end else if (half_cnt == HALF_LAST) begin
                            state <= HOLD;
                        end else begin
                            fhd_sdo_o <= tx[FRAME_W-2];
                            tx        <= {tx[FRAME_W-2:0], 1'b0};
                        end
                    end else begin
                        cnt <= cnt + DIV_ONE;
                    end
                end
                HOLD: begin
                    if (half_done) begin
                        cnt       <= '0;
                        fhd_csn_o <= '1;
                        fhd_sdo_o <= 1'b0;
                        if (rb) begin
                            rdata_o  <= rx;
                            rcs_o    <= cs_idx;
                            rvalid_o <= 1'b1;
                        end
                        state <= GAP;
                    end else begin
                        cnt <= cnt + DIV_ONE;
                    end
                end
                default: begin
                    if (half_done) begin
                        cnt    <= '0;
                        busy_o <= (count != '0);
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt + DIV_ONE;
                    end
                end
            endcase
        end
    end
endmodule
